// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in/parallel-out receiver.
// Holds the FSM state encoding, the default word width and the bit-counter width.
// No logic, so there is no latency or backpressure.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;

    // Bit counter must hold the values 0..WIDTH.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// MSB-first shift register: each enabled cycle shifts s_in into the LSB.
// Latency: one clock per bit. Backpressure: none, because the register shifts whenever en=1.
// clr with en restarts a word, so the first bit ends up in the MSB after WIDTH shifts.
module sipo_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             s_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        nxt = clr ? {{(WIDTH-1){1'b0}}, s_in} : {sr_q[WIDTH-2:0], s_in};
        sr_d = sr_q;
        if (en) begin
            sr_d = nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial receiver: assembles WIDTH MSB-first bits into a registered word; optional even parity (SIPO_PARITY_EN).
// Latency: p_valid rises on the edge that samples the last bit (or the parity bit).
// Backpressure: the word is held until p_ready; a word that completes while the output is full is dropped and overflow is set.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_en,
    input  logic             s_in,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             overflow,
    output logic             par_err,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             p_valid_q, p_valid_d;
    logic             overflow_q, overflow_d;

    logic             sh_en;
    logic             sh_clr;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_nxt;
    logic             word_done;
    logic [WIDTH-1:0] word_dat;

`ifdef SIPO_PARITY_EN
    logic par_bad;
    logic par_err_q;
`endif

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sh_en),
        .clr   (sh_clr),
        .s_in  (s_in),
        .q     (sr_q),
        .nxt   (sr_nxt)
    );

    // In PAR the data bits are already in the register; otherwise the word is still being completed.
    assign word_dat = (state_q == PAR) ? sr_q : sr_nxt;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_en     = 1'b0;
        sh_clr    = 1'b0;
        word_done = 1'b0;
`ifdef SIPO_PARITY_EN
        par_bad   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s_en) begin
                    sh_en     = 1'b1;
                    sh_clr    = 1'b1;
                    bit_cnt_d = CW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (s_en) begin
                    sh_en = 1'b1;
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef SIPO_PARITY_EN
                        state_d   = PAR;
`else
                        state_d   = IDLE;
                        word_done = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            PAR: begin
                if (s_en) begin
                    state_d = IDLE;
                    if ((^sr_q) ^ s_in) begin
                        par_bad = 1'b1;
                    end else begin
                        word_done = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p_data_d   = p_data_q;
        p_valid_d  = p_valid_q;
        overflow_d = overflow_q;
        if (word_done) begin
            if (!p_valid_q || p_ready) begin
                p_data_d  = word_dat;
                p_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            p_data_q   <= '0;
            p_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            p_data_q   <= p_data_d;
            p_valid_q  <= p_valid_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_bad;
        end
    end
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign p_data   = p_data_q;
    assign p_valid  = p_valid_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter: WIDTH, default 4, data bits per word (range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: s_en  input  1  serial-bit qualifier; s_in is sampled only on cycles where s_en=1.
REQ-005 Port: s_in  input  1  serial data, MSB of each word first.
REQ-006 Port: p_data  output  WIDTH  assembled parallel word, registered.
REQ-007 Port: p_valid  output  1  p_data holds an unconsumed word.
REQ-008 Port: p_ready  input  1  consumer accepts p_data when p_valid=1 and p_ready=1.
REQ-009 Port: overflow  output  1  sticky flag: a completed word was dropped.
REQ-010 Port: par_err  output  1  one-cycle pulse on a parity mismatch (see Configuration).
REQ-011 Port: busy  output  1  high while a word is partially received (state SHIFT or PAR).

Function
REQ-012 FSM states: IDLE, SHIFT, PAR; PAR exists only with SIPO_PARITY_EN.
REQ-013 IDLE: on s_en=1, capture s_in as bit WIDTH-1, set bit_cnt=1, go to SHIFT; s_en=0 holds IDLE.
REQ-014 SHIFT: each s_en=1 cycle shifts s_in into the LSB of the shift register and increments bit_cnt; s_en=0 cycles hold all state (gaps allowed, no timeout).
REQ-015 Word completes on the cycle the WIDTH-th bit is sampled; FSM returns to IDLE, or to PAR if parity is enabled.
REQ-016 Completion latency: p_valid rises on the clock edge that samples the last bit (visible the following cycle); p_data = bits in arrival order, first bit in p_data[WIDTH-1].
REQ-017 Handshake: p_data/p_valid stay stable until accepted; on accept with no simultaneous completion, p_valid clears next cycle.
REQ-018 Completion with output register free, or with accept in the same cycle: the new word loads into p_data and p_valid stays or goes 1 (no bubble).
REQ-019 Completion while p_valid=1 and p_ready=0: new word dropped, p_data unchanged, overflow set to 1.
REQ-020 overflow clears only on reset.
REQ-021 A back-to-back stream (s_en held 1) is accepted without a dead cycle between words.
REQ-022 The shift register and bit_cnt are independent of the output register; reception continues while p_valid=1.

Reset
REQ-023 rst_n=0 asynchronously forces: state=IDLE, bit_cnt=0, shift register=0, p_data=0, p_valid=0, overflow=0, par_err=0, busy=0.
REQ-024 Reset mid-word discards the partial word; the first s_en=1 cycle after release starts a new word.

Configuration
REQ-025 Macro SIPO_PARITY_EN defined: after WIDTH data bits, one more s_en=1 bit is sampled in PAR as the even-parity bit over the data bits.
REQ-026 Parity matches: the word is delivered per REQ-018/019. Mismatch: the word is discarded and par_err pulses 1 for one cycle. PAR then returns to IDLE.
REQ-027 SIPO_PARITY_EN undefined: no PAR state, par_err tied to 0, framing is WIDTH bits.

Structure
REQ-028 Shared package sipo_pkg holds: the FSM state typedef (IDLE, SHIFT, PAR), the WIDTH default constant, and the bit-counter width function (clog2 of WIDTH+1).
REQ-029 One sub-module, sipo_shift_reg (WIDTH-bit, enable-gated, MSB-first shift with async active-low reset), instantiated once; FSM, counter and output register stay in sipo_rx.

Verification (WIDTH=4)
REQ-030 Reset, then s_en=1 with s_in=1,0,1,1 and p_ready=1 -> p_data=4'b1011 and p_valid=1 for exactly one cycle, overflow=0.
REQ-031 Same word with s_en gaps (1,0,0,1,1,0,1) -> p_data=4'b1011 with no error; busy=1 throughout the gaps.
REQ-032 Words 4'hA then 4'h5, s_en held 1, p_ready=0 -> p_data stays 4'hA, overflow=1 after the 8th bit; raise p_ready -> 4'hA accepted and p_valid=0.
REQ-033 Continuous 4'h3, 4'hC, 4'hF with p_ready=1 -> three p_valid pulses exactly 4 cycles apart, no loss.
REQ-034 rst_n pulsed low after 2 bits of a word -> outputs return to reset values immediately; the next 4 bits 0,1,1,0 yield p_data=4'h6.
REQ-035 With SIPO_PARITY_EN: 1,0,1,1 + parity 1 -> p_data=4'hB delivered; 1,0,1,1 + parity 0 -> par_err pulses and p_valid stays 0.
